cd_oven_sp_ramp: RTL and testbench

CD_OVEN_SP_RAMP -- requirements
Module: cd_oven_sp_ramp

---
 rtl/cd_oven_pkg.sv | 11 +
 rtl/cd_ramp_tick.sv | 29 ++
 rtl/cd_oven_sp_ramp.sv | 127 ++++++++++++
 tb/tb_cd_oven_sp_ramp.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cd_oven_pkg.sv
// rtl/cd_oven_pkg.sv - shared state enum and default widths for the oven setpoint ramp
package cd_oven_pkg;
  localparam int FILTER_IO_SIZE_DEF = 18;
  localparam int DIV_SIZE_DEF       = 16;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } sp_state_t;
endpackage

// File: rtl/cd_ramp_tick.sv
// rtl/cd_ramp_tick.sv - ramp rate divider, tick when counter reaches rate_div then wraps
module cd_ramp_tick
  import cd_oven_pkg::*;
#(
  parameter int DIV_SIZE = DIV_SIZE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic [DIV_SIZE-1:0] rate_div,
  output logic                tick
);

  logic [DIV_SIZE-1:0] cnt;

  // >= so a counter left above a freshly lowered rate_div still ticks and wraps
  assign tick = (cnt >= rate_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + {{(DIV_SIZE-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/cd_oven_sp_ramp.sv
// rtl/cd_oven_sp_ramp.sv - slew-limited setpoint between parameter stage and PID servo
// Optional bumpless start from temp_in in OFF: CD_SP_RAMP_BUMPLESS_EN
module cd_oven_sp_ramp
  import cd_oven_pkg::*;
#(
  parameter int FILTER_IO_SIZE = FILTER_IO_SIZE_DEF,
  parameter int DIV_SIZE       = DIV_SIZE_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             PI_on_in,
  input  logic signed [FILTER_IO_SIZE-1:0] sp_in,
  input  logic signed [FILTER_IO_SIZE-1:0] temp_in,
  input  logic        [DIV_SIZE-1:0]       rate_div,
  input  logic        [7:0]                step,
  output logic signed [FILTER_IO_SIZE-1:0] sp_out,
  output logic                             PI_on_out,
  output logic                             ramping,
  output logic                             at_sp
);

  localparam int W = FILTER_IO_SIZE;
  localparam logic signed [W:0] MAX_EXT = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] MIN_EXT = {2'b11, {(W-1){1'b0}}};

  sp_state_t state;
  logic      tick;
  logic      clr;

  logic              [7:0] step_eff;
  logic signed       [W:0] diff;
  logic signed       [W:0] mag;
  logic signed       [W:0] eff;
  logic signed       [W:0] moved;
  logic signed     [W-1:0] sp_next;
  logic                    close;

  // counter only runs in RAMP, so it is already 0 on every entry
  assign clr = (state != RAMP);

  cd_ramp_tick #(.DIV_SIZE(DIV_SIZE)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .rate_div (rate_div),
    .tick     (tick)
  );

  always_comb begin
    step_eff = (step == 8'd0) ? 8'd1 : step;
    diff     = {sp_in[W-1], sp_in} - {sp_out[W-1], sp_out};
    mag      = diff[W] ? -diff : diff;
    eff      = {{(W-7){1'b0}}, step_eff};
    close    = (mag <= eff);
    moved    = diff[W] ? ({sp_out[W-1], sp_out} - eff) : ({sp_out[W-1], sp_out} + eff);
    if (moved > MAX_EXT) begin
      sp_next = MAX_EXT[W-1:0];
    end else if (moved < MIN_EXT) begin
      sp_next = MIN_EXT[W-1:0];
    end else begin
      sp_next = moved[W-1:0];
    end
  end

`ifndef CD_SP_RAMP_BUMPLESS_EN
  logic unused_temp_in;
  assign unused_temp_in = ^temp_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OFF;
      sp_out    <= '0;
      PI_on_out <= 1'b0;
      ramping   <= 1'b0;
      at_sp     <= 1'b0;
    end else if (!PI_on_in) begin
      state     <= OFF;
      PI_on_out <= 1'b0;
      ramping   <= 1'b0;
      at_sp     <= 1'b0;
`ifdef CD_SP_RAMP_BUMPLESS_EN
      sp_out    <= temp_in;
`endif
    end else begin
      case (state)
        OFF: begin
          state     <= RAMP;
          PI_on_out <= 1'b1;
          ramping   <= 1'b1;
          at_sp     <= 1'b0;
`ifdef CD_SP_RAMP_BUMPLESS_EN
          sp_out    <= temp_in;
`endif
        end
        RAMP: begin
          if (tick) begin
            if (close) begin
              sp_out  <= sp_in;
              state   <= HOLD;
              ramping <= 1'b0;
              at_sp   <= 1'b1;
            end else begin
              sp_out  <= sp_next;
            end
          end
        end
        HOLD: begin
          if (close) begin
            sp_out  <= sp_in;
          end else begin
            state   <= RAMP;
            ramping <= 1'b1;
            at_sp   <= 1'b0;
          end
        end
        default: begin
          state     <= OFF;
          PI_on_out <= 1'b0;
          ramping   <= 1'b0;
          at_sp     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cd_oven_sp_ramp.sv
// tb/tb_cd_oven_sp_ramp.sv - directed self-checking bench for cd_oven_sp_ramp
module tb_cd_oven_sp_ramp;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               PI_on_in;
  logic signed [17:0] sp_in;
  logic signed [17:0] temp_in;
  logic        [15:0] rate_div;
  logic         [7:0] step;
  logic signed [17:0] sp_out;
  logic               PI_on_out;
  logic               ramping;
  logic               at_sp;

  int errors = 0;
  int checks = 0;

  cd_oven_sp_ramp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PI_on_in  (PI_on_in),
    .sp_in     (sp_in),
    .temp_in   (temp_in),
    .rate_div  (rate_div),
    .step      (step),
    .sp_out    (sp_out),
    .PI_on_out (PI_on_out),
    .ramping   (ramping),
    .at_sp     (at_sp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int exp_off;

    rst_n    = 1'b0;
    PI_on_in = 1'b0;
    sp_in    = -18'sd25;
    temp_in  = 18'sd0;
    rate_div = 16'd0;
    step     = 8'd10;
    #2;
    chk("reset_sp_out", int'(sp_out), 0);
    chk("reset_pi_on", int'(PI_on_out), 0);
    chk("reset_ramping", int'(ramping), 0);
    chk("reset_at_sp", int'(at_sp), 0);

    edge_step();
    rst_n = 1'b1;
    edge_step();
    edge_step();
    chk("off_pi_on", int'(PI_on_out), 0);
    chk("off_sp_out", int'(sp_out), 0);

    // non-multiple landing toward -25, step 10, every cycle
    PI_on_in = 1'b1;
    edge_step();
    chk("enable_pi_on", int'(PI_on_out), 1);
    chk("enable_ramping", int'(ramping), 1);
    chk("enable_sp_out", int'(sp_out), 0);
    edge_step();
    chk("land_sp1", int'(sp_out), -10);
    edge_step();
    chk("land_sp2", int'(sp_out), -20);
    edge_step();
    chk("land_sp3", int'(sp_out), -25);
    chk("land_at_sp", int'(at_sp), 1);
    chk("land_ramping", int'(ramping), 0);

    // small retarget in HOLD
    sp_in = -18'sd20;
    edge_step();
    chk("hold_small_sp", int'(sp_out), -20);
    chk("hold_small_at_sp", int'(at_sp), 1);

    // large retarget: back to RAMP then 255-LSB steps to 1100
    sp_in = 18'sd1100;
    step  = 8'd255;
    edge_step();
    chk("reramp_ramping", int'(ramping), 1);
    chk("reramp_sp", int'(sp_out), -20);
    for (int i = 0; i < 4; i++) edge_step();
    chk("reramp_sp4", int'(sp_out), 1000);
    edge_step();
    chk("reramp_land", int'(sp_out), 1100);
    chk("reramp_at_sp", int'(at_sp), 1);

    sp_in = 18'sd1105;
    step  = 8'd10;
    edge_step();
    chk("hold_1105_sp", int'(sp_out), 1105);
    chk("hold_1105_at_sp", int'(at_sp), 1);
    sp_in = 18'sd1200;
    edge_step();
    chk("hold_1200_ramping", int'(ramping), 1);
    chk("hold_1200_sp", int'(sp_out), 1105);

    // divider: rate_div=3 steps every 4th edge; then lowered mid-count
    rate_div = 16'd3;
    for (int i = 0; i < 3; i++) edge_step();
    chk("div_no_step", int'(sp_out), 1105);
    edge_step();
    chk("div_step", int'(sp_out), 1115);
    edge_step();
    edge_step();
    rate_div = 16'd1;
    edge_step();
    chk("div_lowered", int'(sp_out), 1125);
    edge_step();
    chk("div1_wait", int'(sp_out), 1125);
    edge_step();
    chk("div1_step", int'(sp_out), 1135);

    // disable mid-ramp
    temp_in  = 18'sd777;
    PI_on_in = 1'b0;
`ifdef CD_SP_RAMP_BUMPLESS_EN
    exp_off = 777;
`else
    exp_off = 1135;
`endif
    edge_step();
    chk("dis_pi_on", int'(PI_on_out), 0);
    chk("dis_ramping", int'(ramping), 0);
    chk("dis_sp", int'(sp_out), exp_off);

    // long ramp toward 131000, then saturating neighbourhood
    temp_in  = 18'sd1135;
    edge_step();
    sp_in    = 18'sd131000;
    step     = 8'd255;
    rate_div = 16'd0;
    PI_on_in = 1'b1;
    edge_step();
    n = 0;
    while (!at_sp && n < 1000) begin
      edge_step();
      n++;
    end
    chk("sat_reach_hold", int'(at_sp), 1);
    chk("sat_reach_sp", int'(sp_out), 131000);
    sp_in = 18'sd131071;
    edge_step();
    chk("sat_top_sp", int'(sp_out), 131071);
    chk("sat_top_at_sp", int'(at_sp), 1);

    // step=0 behaves as 1
    sp_in = 18'sd131069;
    step  = 8'd0;
    edge_step();
    chk("step0_ramping", int'(ramping), 1);
    edge_step();
    chk("step0_sp1", int'(sp_out), 131070);
    edge_step();
    chk("step0_sp2", int'(sp_out), 131069);
    chk("step0_at_sp", int'(at_sp), 1);

    // full-span retarget, difference needs the extra bit
    sp_in = -18'sd131072;
    step  = 8'd255;
    edge_step();
    edge_step();
    chk("span_sp", int'(sp_out), 130814);
    chk("span_ramping", int'(ramping), 1);
    edge_step();

    // asynchronous reset mid-cycle during RAMP
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset_sp", int'(sp_out), 0);
    chk("areset_pi_on", int'(PI_on_out), 0);
    chk("areset_ramping", int'(ramping), 0);
    chk("areset_at_sp", int'(at_sp), 0);
    edge_step();
    chk("areset_hold_pi_on", int'(PI_on_out), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
